quad_encoder_emulator: RTL and testbench

- Generates a two-channel quadrature signal pair (codeA/codeB) from a commanded edge period, direction and edge count.
- Drives the wheel-count decoder inputs for hardware-in-loop testing and bench self-test in place of a physical encoder.
- Accepts commands over a valid/ready handshake and reports its own signed position, so decoder output can be cross-checked against it.

---
 rtl/wheel_pkg.sv | 28 ++
 rtl/quad_edge_timer.sv | 29 ++
 rtl/quad_encoder_emulator.sv | 106 ++++++++++
 tb/tb_quad_encoder_emulator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wheel_pkg.sv
// Shared types and the quadrature phase-step helper for the wheel encoder emulator.
package wheel_pkg;

    // {A,B}: bit 1 is channel A, bit 0 is channel B.
    typedef logic [1:0] quad_phase_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } emu_state_t;

    localparam int MIN_PERIOD_DEFAULT = 4;

    // Forward walks 00 -> 10 -> 11 -> 01; reverse walks the same ring backwards.
    function automatic quad_phase_t next_phase(input quad_phase_t phase, input logic dir);
        quad_phase_t nxt;
        nxt = phase;
        case (phase)
            2'b00:   nxt = dir ? 2'b10 : 2'b01;
            2'b10:   nxt = dir ? 2'b11 : 2'b00;
            2'b11:   nxt = dir ? 2'b01 : 2'b10;
            2'b01:   nxt = dir ? 2'b00 : 2'b11;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// Period counter for the encoder emulator: counts 0..period-1 and strobes tick on the last count.
module quad_edge_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] period,
    output logic         tick
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    assign tick = enable && (count == (period - ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns period/direction/step commands into an A/B edge stream.
//
// Command handshake: a command transfers in any cycle where cmd_valid && cmd_ready
// at the clock edge; cmd_ready is high in IDLE and in continuous RUN unless abort is high.
module quad_encoder_emulator
    import wheel_pkg::*;
#(
    parameter int MIN_PERIOD    = MIN_PERIOD_DEFAULT,
    parameter int EDGES_PER_REV = 2048,
    parameter int W             = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_period,
    input  logic         cmd_dir,
    input  logic [W-1:0] cmd_steps,
    input  logic         abort,
    output logic         codeA,
    output logic         codeB,
    output logic         index,
    output logic [W-1:0] position,
    output logic         busy,
    output logic         done,
    output emu_state_t   state
);

    localparam logic [W-1:0] ONE = W'(1);

    quad_phase_t  phase;
    logic [W-1:0] per_q;
    logic         dir_q;
    logic [W-1:0] remaining;
    logic [W-1:0] eff_period;
    logic [W-1:0] pos_next;
    logic         continuous;
    logic         accept;
    logic         tick;
    logic         timer_en;
    logic         timer_clear;

    assign eff_period  = (cmd_period < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : cmd_period;
    // remaining is only zero in RUN when the command asked for an unbounded run.
    assign continuous  = (remaining == '0);
    assign cmd_ready   = ((state == IDLE) || continuous) && !abort;
    assign accept      = cmd_valid && cmd_ready;
    assign timer_en    = (state == RUN) && !abort;
    assign timer_clear = accept || abort;
    assign pos_next    = dir_q ? (position + ONE) : (position - ONE);

    assign codeA = phase[1];
    assign codeB = phase[0];
    assign busy  = (state == RUN);

    quad_edge_timer #(
        .W(W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .period (per_q),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= 2'b00;
            position  <= '0;
            per_q     <= W'(MIN_PERIOD);
            dir_q     <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
            index     <= 1'b0;
        end else begin
            done  <= 1'b0;
            index <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                // An edge coinciding with a continuous-mode accept still uses the old dir.
                if (tick) begin
                    phase    <= next_phase(phase, dir_q);
                    position <= pos_next;
                    index    <= ((pos_next % W'(EDGES_PER_REV)) == '0);
                    if (!continuous) begin
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                if (accept) begin
                    state     <= RUN;
                    per_q     <= eff_period;
                    dir_q     <= cmd_dir;
                    remaining <= cmd_steps;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator: directed scenarios plus random commands vs a model.
module tb_quad_encoder_emulator;
    import wheel_pkg::*;

    localparam int W   = 32;
    localparam int EPR = 4;
    localparam int MINP = 4;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_period;
    logic         cmd_dir;
    logic [W-1:0] cmd_steps;
    logic         abort;
    logic         codeA;
    logic         codeB;
    logic         index;
    logic [W-1:0] position;
    logic         busy;
    logic         done;
    emu_state_t   state;

    quad_encoder_emulator #(
        .MIN_PERIOD    (MINP),
        .EDGES_PER_REV (EPR),
        .W             (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_period (cmd_period),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
        .codeA      (codeA),
        .codeB      (codeB),
        .index      (index),
        .position   (position),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driven values, applied at each negedge by step_cycle
    logic         d_valid;
    logic [W-1:0] d_period;
    logic         d_dir;
    logic [W-1:0] d_steps;
    logic         d_abort;

    // reference model: phase as a step index into the forward ring, countdown to next edge
    logic [1:0]   ab_tab [4];
    bit           m_run;
    int           m_cd;
    int           m_per;
    bit           m_dir;
    logic [W-1:0] m_rem;
    int           m_step;
    logic [W-1:0] m_pos;
    bit           m_done;
    bit           m_index;
    bit           m_accepted;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_pos;

    task automatic model_reset();
        m_run = 0; m_cd = 0; m_per = MINP; m_dir = 0; m_rem = '0;
        m_step = 0; m_pos = '0; m_done = 0; m_index = 0; m_accepted = 0;
        exp_q.delete();
        last_pos = '0;
    endtask

    task automatic model_update(input bit ready);
        m_accepted = 0;
        m_done     = 0;
        m_index    = 0;
        if (d_abort) begin
            m_run = 0;
        end else begin
            if (m_run && m_cd == 1) begin
                m_step  = m_dir ? (m_step + 1) % 4 : (m_step + 3) % 4;
                m_pos   = m_dir ? m_pos + 1 : m_pos - 1;
                m_index = ((m_pos % EPR) == 0);
                exp_q.push_back(m_pos);
                m_cd = m_per;
                if (m_rem != 0) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end else if (m_run) begin
                m_cd--;
            end
            if (d_valid && ready) begin
                m_accepted = 1;
                m_run = 1;
                m_per = (d_period < MINP) ? MINP : int'(d_period);
                m_cd  = m_per;
                m_dir = d_dir;
                m_rem = d_steps;
            end
        end
    endtask

    // one clock: check outputs from the previous edge, drive inputs, check ready, advance model
    task automatic step_cycle();
        bit ready;
        @(negedge clk);
        check_val("codeA", codeA, ab_tab[m_step][1]);
        check_val("codeB", codeB, ab_tab[m_step][0]);
        check_val("position", position, m_pos);
        check_val("busy", busy, m_run);
        check_val("state", W'(state), m_run ? 1 : 0);
        check_val("done", done, m_done);
        check_val("index", index, m_index);
        if (position !== last_pos) begin
            if (exp_q.size() == 0) check_val("edge_unexpected", position, last_pos);
            else check_val("edge_pos", position, exp_q.pop_front());
            last_pos = position;
        end
        cmd_valid  = d_valid;
        cmd_period = d_period;
        cmd_dir    = d_dir;
        cmd_steps  = d_steps;
        abort      = d_abort;
        #1;
        ready = (!m_run || m_rem == 0) && !d_abort;
        check_val("cmd_ready", cmd_ready, ready);
        model_update(ready);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic send_cmd(input int period, input bit dir, input int steps);
        bit ok = 0;
        d_valid = 1; d_period = W'(period); d_dir = dir; d_steps = W'(steps);
        for (int i = 0; i < 200 && !ok; i++) begin
            step_cycle();
            ok = m_accepted;
        end
        d_valid = 0;
        if (!ok) check_val("cmd_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (m_run && i < budget) begin
            step_cycle();
            i++;
        end
        if (m_run) check_val("idle_timeout", 0, 1);
    endtask

    task automatic wait_model_pos(input logic [W-1:0] target, input int budget);
        int i = 0;
        while (m_pos != target && i < budget) begin
            step_cycle();
            i++;
        end
        if (m_pos != target) check_val("pos_timeout", m_pos, target);
    endtask

    // async reset asserted away from the clock edge; outputs must clear at once
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_codeA", codeA, 0);
        check_val("rst_codeB", codeB, 0);
        check_val("rst_position", position, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_index", index, 0);
        model_reset();
        d_valid = 0; d_abort = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [W-1:0] held_pos;

    initial begin
        ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;
        rst = 1'b0;
        cmd_valid = 0; cmd_period = '0; cmd_dir = 0; cmd_steps = '0; abort = 0;
        d_valid = 0; d_period = '0; d_dir = 0; d_steps = '0; d_abort = 0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        idle_cycles(3);

        // counted forward run of 8 edges at period 10
        send_cmd(10, 1, 8);
        wait_idle(200);
        step_cycle();
        check_val("s1_position", position, 8);
        check_val("s1_phase", {codeA, codeB}, 2'b00);

        // period below minimum clamps; reverse 4 edges from reset
        do_reset();
        send_cmd(2, 0, 4);
        wait_idle(100);
        step_cycle();
        check_val("s2_position", position, 32'hFFFF_FFFC);

        // continuous forward, then reverse at a new period without losing a phase
        do_reset();
        send_cmd(5, 1, 0);
        wait_model_pos(3, 100);
        send_cmd(7, 0, 0);
        wait_model_pos(1, 100);
        step_cycle();
        check_val("s3_position", position, 1);
        check_val("s3_phase", {codeA, codeB}, 2'b10);

        // abort together with a command mid counted run
        do_reset();
        send_cmd(6, 1, 20);
        idle_cycles(10);
        d_abort = 1; d_valid = 1; d_period = 3; d_dir = 0; d_steps = 5;
        step_cycle();
        d_abort = 0; d_valid = 0;
        step_cycle();
        check_val("s5_busy", busy, 0);
        check_val("s5_ready", cmd_ready, 1);
        held_pos = position;
        idle_cycles(12);
        check_val("s5_frozen", position, held_pos);

        // randomized commands, reversals, aborts and retargets
        for (int n = 0; n < 4000; n++) begin
            d_abort = ($urandom_range(0, 99) == 0);
            if (!d_valid && $urandom_range(0, 14) == 0) begin
                d_valid  = 1;
                d_period = W'($urandom_range(0, 9));
                d_dir    = 1'($urandom_range(0, 1));
                d_steps  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 12));
            end
            step_cycle();
            if (m_accepted || d_abort) d_valid = 0;
        end
        d_valid = 0; d_abort = 1;
        step_cycle();
        d_abort = 0;
        idle_cycles(3);
        check_val("edge_q_drain", W'(exp_q.size()), 0);

        // async reset while a continuous run is active
        send_cmd(4, 1, 0);
        idle_cycles(30);
        do_reset();
        idle_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
